// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller with an optional first-word-fall-through read
// mode, almost-full/almost-empty thresholds, an occupancy count, a
// synchronous flush and sticky overflow/underflow flags.
// A write to a full FIFO is accepted when a read is accepted in the same
// cycle, so a full FIFO can stream at one word per cycle.
module fifo_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int PTR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int LVL_W = PTR_WIDTH + 1;
  localparam logic [LVL_W-1:0] LVL_DEPTH  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic rd_acc, wr_acc;
  logic rd_do, wr_do;

  // Status flags derived from the registered occupancy only.
  always_comb begin
    full         = (level_q == LVL_DEPTH);
    empty        = (level_q == '0);
    almost_full  = (level_q >= LVL_AFULL);
    almost_empty = (level_q <= LVL_AEMPTY);
    level        = level_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Acceptance, pointer, occupancy and error-flag next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    rd_acc = rd_en & ~empty;
    wr_acc = wr_en & (~full | rd_acc);
    // Flush overrides both accesses; rejected accesses never move state.
    rd_do  = rd_acc & ~flush;
    wr_do  = wr_acc & ~flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_do) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (rd_do) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      case ({wr_do, rd_do})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    // Clear first so a set in the same cycle wins.
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en & ~wr_acc & ~flush) overflow_d  = 1'b1;
    if (rd_en & empty & ~flush)   underflow_d = 1'b1;
  end

  // Control state registers; reset discards all entries immediately.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; occupancy tracking makes stale contents
    // unobservable and keeps the array mappable to plain RAM.
    if (wr_do) mem[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

      // Registered read: load head on an accepted read, otherwise hold.
      always_comb begin
        data_out_d = data_out_q;
        if (rd_do) data_out_d = mem[rd_ptr_q];
      end

      // Read data register.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) data_out_q <= '0;
        else         data_out_q <= data_out_d;
      end

      assign data_out = data_out_q;
    end else begin : g_fwft
      // Head of queue presented directly; forced to zero while empty so the
      // output never shows stale array contents.
      assign data_out = empty ? '0 : mem[rd_ptr_q];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: one standard-mode and one FWFT instance. Stimulus
// pushes expected results, tagged with the cycle they are due, into a
// scoreboard; a monitor on the falling edge pops and compares them.
module tb_fifo_ctrl;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Standard-mode instance signals
  logic          s_flush, s_wr, s_rd, s_clr;
  logic [DW-1:0] s_din, s_dout;
  logic          s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
  logic [4:0]    s_level;

  // FWFT instance signals
  logic          f_flush, f_wr, f_rd, f_clr;
  logic [DW-1:0] f_din, f_dout;
  logic          f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf;
  logic [4:0]    f_level;

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(16), .FWFT(0),
              .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_std (
    .clk(clk), .resetn(resetn), .flush(s_flush), .wr_en(s_wr),
    .data_in(s_din), .full(s_full), .almost_full(s_afull), .rd_en(s_rd),
    .data_out(s_dout), .empty(s_empty), .almost_empty(s_aempty),
    .level(s_level), .overflow(s_ovf), .underflow(s_udf), .clear_err(s_clr)
  );

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(16), .FWFT(1),
              .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_fw (
    .clk(clk), .resetn(resetn), .flush(f_flush), .wr_en(f_wr),
    .data_in(f_din), .full(f_full), .almost_full(f_afull), .rd_en(f_rd),
    .data_out(f_dout), .empty(f_empty), .almost_empty(f_aempty),
    .level(f_level), .overflow(f_ovf), .underflow(f_udf), .clear_err(f_clr)
  );

  typedef enum int {K_DOUT, K_LEVEL, K_FULL, K_EMPTY, K_AFULL, K_AEMPTY,
                    K_OVF, K_UDF} kind_e;

  typedef struct {
    bit      fw;
    kind_e   kind;
    string   name;
    logic [DW-1:0] val;
    int      due;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] get_act(input bit fw, input kind_e k);
    logic [DW-1:0] r;
    r = '0;
    case (k)
      K_DOUT:   r = fw ? f_dout : s_dout;
      K_LEVEL:  r = DW'(fw ? f_level : s_level);
      K_FULL:   r = DW'(fw ? f_full : s_full);
      K_EMPTY:  r = DW'(fw ? f_empty : s_empty);
      K_AFULL:  r = DW'(fw ? f_afull : s_afull);
      K_AEMPTY: r = DW'(fw ? f_aempty : s_aempty);
      K_OVF:    r = DW'(fw ? f_ovf : s_ovf);
      K_UDF:    r = DW'(fw ? f_udf : s_udf);
      default:  r = '0;
    endcase
    return r;
  endfunction

  // dly=0: current state; dly=1: result of the inputs driven this cycle.
  task automatic expect_val(input bit fw, input kind_e k, input string name,
                            input logic [DW-1:0] v, input int dly);
    exp_t e;
    e.fw = fw; e.kind = k; e.name = name; e.val = v; e.due = cyc + dly;
    sb.push_back(e);
  endtask

  // Monitor: compare every entry that falls due this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, get_act(sb[i].fw, sb[i].kind), sb[i].val);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: expectation never compared (due %0d)", sb[i].name, sb[i].due);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_state(input bit fw, input string tag);
    expect_val(fw, K_LEVEL,  {tag, "_level"},  0, 0);
    expect_val(fw, K_EMPTY,  {tag, "_empty"},  1, 0);
    expect_val(fw, K_AEMPTY, {tag, "_aempty"}, 1, 0);
    expect_val(fw, K_FULL,   {tag, "_full"},   0, 0);
    expect_val(fw, K_AFULL,  {tag, "_afull"},  0, 0);
    expect_val(fw, K_OVF,    {tag, "_ovf"},    0, 0);
    expect_val(fw, K_UDF,    {tag, "_udf"},    0, 0);
    if (!fw) expect_val(fw, K_DOUT, {tag, "_dout"}, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    s_flush = 0; s_wr = 0; s_rd = 0; s_clr = 0; s_din = '0;
    f_flush = 0; f_wr = 0; f_rd = 0; f_clr = 0; f_din = '0;
    tick();
    expect_reset_state(0, "rst_std");
    expect_reset_state(1, "rst_fw");
    tick();
    resetn = 1'b1;
    tick();

    // 1: fill with 0x100..0x10F
    for (int i = 0; i < 16; i++) begin
      s_wr = 1; s_din = 32'h100 + i;
      expect_val(0, K_LEVEL,  "fill_level",  i + 1, 1);
      expect_val(0, K_AEMPTY, "fill_aempty", (i + 1 <= 2) ? 1 : 0, 1);
      expect_val(0, K_AFULL,  "fill_afull",  (i + 1 >= 14) ? 1 : 0, 1);
      expect_val(0, K_FULL,   "fill_full",   (i + 1 == 16) ? 1 : 0, 1);
      tick();
    end
    s_wr = 0;
    expect_val(0, K_OVF, "fill_ovf", 0, 0);

    // 2: write to full is rejected, overflow sticky, clear_err clears it
    s_wr = 1; s_din = 32'hDEAD;
    expect_val(0, K_OVF,   "ovf_set",   1, 1);
    expect_val(0, K_LEVEL, "ovf_level", 16, 1);
    tick();
    s_wr = 0;
    expect_val(0, K_OVF, "ovf_sticky", 1, 1);
    tick();
    s_clr = 1;
    expect_val(0, K_OVF, "ovf_clear", 0, 1);
    tick();
    s_clr = 0;

    // 3: simultaneous write+read on full, then drain
    s_wr = 1; s_rd = 1; s_din = 32'hBEEF;
    expect_val(0, K_DOUT,  "fullrw_dout",  32'h100, 1);
    expect_val(0, K_LEVEL, "fullrw_level", 16, 1);
    expect_val(0, K_OVF,   "fullrw_ovf",   0, 1);
    tick();
    s_wr = 0;
    for (int i = 0; i < 16; i++) begin
      s_rd = 1;
      expect_val(0, K_DOUT,  "drain_dout",  (i < 15) ? 32'h101 + i : 32'hBEEF, 1);
      expect_val(0, K_LEVEL, "drain_level", 15 - i, 1);
      tick();
    end
    s_rd = 0;
    expect_val(0, K_EMPTY, "drain_empty", 1, 0);
    expect_val(0, K_UDF,   "drain_udf",   0, 0);

    // 4: read+write on empty: read rejected, write accepted
    s_rd = 1; s_wr = 1; s_din = 32'h55;
    expect_val(0, K_UDF,   "udf_set",   1, 1);
    expect_val(0, K_LEVEL, "udf_level", 1, 1);
    expect_val(0, K_DOUT,  "udf_dout_hold", 32'hBEEF, 1);
    tick();
    s_wr = 0;
    expect_val(0, K_DOUT,  "udf_next_dout", 32'h55, 1);
    expect_val(0, K_LEVEL, "udf_next_level", 0, 1);
    tick();
    s_rd = 0; s_clr = 1;
    expect_val(0, K_UDF, "udf_clear", 0, 1);
    tick();
    s_clr = 0;

    // 5: FWFT behaviour
    f_wr = 1; f_din = 32'hA1;
    expect_val(1, K_EMPTY, "fw_empty_before", 1, 0);
    expect_val(1, K_EMPTY, "fw_empty_fall", 0, 1);
    expect_val(1, K_DOUT,  "fw_first_word", 32'hA1, 1);
    tick();
    f_din = 32'hA2;
    expect_val(1, K_DOUT,  "fw_head_held", 32'hA1, 1);
    expect_val(1, K_LEVEL, "fw_level2", 2, 1);
    tick();
    f_wr = 0; f_rd = 1;
    expect_val(1, K_DOUT,  "fw_pop_next", 32'hA2, 1);
    expect_val(1, K_LEVEL, "fw_level1", 1, 1);
    tick();
    expect_val(1, K_EMPTY, "fw_empty_again", 1, 1);
    tick();
    expect_val(1, K_UDF, "fw_udf", 1, 1);
    tick();
    f_rd = 0;

    // 6: flush with concurrent write
    for (int i = 0; i < 5; i++) begin
      s_wr = 1; s_din = 32'h200 + i;
      tick();
    end
    s_wr = 1; s_flush = 1; s_din = 32'h999;
    expect_val(0, K_LEVEL, "flush_level_before", 5, 0);
    expect_val(0, K_LEVEL, "flush_level", 0, 1);
    expect_val(0, K_EMPTY, "flush_empty", 1, 1);
    expect_val(0, K_OVF,   "flush_ovf", 0, 1);
    expect_val(0, K_UDF,   "flush_udf", 0, 1);
    expect_val(0, K_DOUT,  "flush_dout_hold", 32'h55, 1);
    tick();
    s_flush = 0; s_wr = 0;
    expect_val(0, K_LEVEL, "flush_level_stays", 0, 1);
    tick();
    s_wr = 1; s_din = 32'h300;
    tick();
    s_wr = 0; s_rd = 1;
    expect_val(0, K_DOUT, "post_flush_dout", 32'h300, 1);
    tick();
    s_rd = 0;

    // Reset asserted mid-burst, between clock edges
    s_wr = 1; s_din = 32'h400;
    tick();
    s_din = 32'h401;
    tick();
    resetn = 1'b0;
    expect_reset_state(0, "midrst");
    tick();
    s_wr = 0;
    resetn = 1'b1;
    tick();

    // Wrap: 40 write/read pairs across pointer wrap
    for (int i = 0; i < 40; i++) begin
      s_wr = 1; s_din = 32'h1000 + i;
      tick();
      s_wr = 0; s_rd = 1;
      expect_val(0, K_DOUT, "wrap_dout", 32'h1000 + i, 1);
      tick();
      s_rd = 0;
    end
    expect_val(0, K_LEVEL, "wrap_level", 0, 0);

    tick();
    tick();
    tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Parametrised synchronous FIFO. It is the successor of the basic FIFO used in the SoC data paths between the PicoRV32 bus side and the DDR model. It adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy output, a synchronous flush, and sticky overflow/underflow error flags. It also accepts a write to a full FIFO when a read happens in the same cycle.

Parameters:
DATA_WIDTH, 32, entry width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_THRESH, DEPTH-2, almost_full asserts when level >= this value; legal range 1..DEPTH
AEMPTY_THRESH, 2, almost_empty asserts when level <= this value; legal range 0..DEPTH-1
PTR_WIDTH, $clog2(DEPTH), derived; not overridden

Ports:
clk  in  1  clock; all logic on the rising edge
resetn  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of contents
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
full  out  1  level == DEPTH
almost_full  out  1  level >= AFULL_THRESH
rd_en  in  1  read request (FWFT: pop/acknowledge of head)
data_out  out  DATA_WIDTH  read data
empty  out  1  level == 0
almost_empty  out  1  level <= AEMPTY_THRESH
level  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected
clear_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (resetn=0, async assert, sync-released deassert expected):
  - wr_ptr, rd_ptr and level are 0.
  - data_out=0, empty=1, almost_empty=1, full=0.
  - almost_full = (AFULL_THRESH==0) is impossible by range, so almost_full=0.
  - overflow=0, underflow=0.
  - Memory contents are not reset.
  - A reset in mid-operation discards all entries immediately.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd_en & ~empty
  - wr_acc = wr_en & (~full | rd_acc)
  - A write to a full FIFO with a simultaneous accepted read is accepted; level is unchanged.
  - A read from an empty FIFO is never accepted, even with a simultaneous write.
- Pointers: wr_ptr and rd_ptr increment by 1 on acceptance and wrap from DEPTH-1 to 0 naturally.
- Level update:
  - +1 when only wr_acc
  - -1 when only rd_acc
  - unchanged when both or neither
- full, empty, almost_full and almost_empty are combinational from the level register. They change in the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On rd_acc, data_out is loaded with mem[rd_ptr] at the edge; one-cycle read latency.
  - Otherwise data_out holds its value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; valid whenever empty=0.
  - rd_acc advances to the next entry.
  - A word written into an empty FIFO is visible on data_out the cycle after the write edge, when empty falls.
  - data_out is don't-care while empty=1.
- Flush:
  - On an edge with flush=1: pointers and level go to 0; wr_en and rd_en are ignored that cycle.
  - No error flags are set that cycle; data_out holds (FWFT=0).
  - Flush has priority over all other operations except reset.
- Error flags:
  - overflow sets on an edge with wr_en & ~wr_acc & ~flush.
  - underflow sets on an edge with rd_en & empty & ~flush.
  - Both stay set until a clear_err edge. Set has priority over clear in the same cycle.
  - A rejected access never modifies pointers, level or memory.

Test Plan:
1. DEPTH=16, FWFT=0, AFULL=14, AEMPTY=2. Write 0x100..0x10F on 16 consecutive cycles.
   -> level steps 1..16; almost_empty falls when level=3; almost_full rises when level=14; full=1 after the 16th write; overflow=0.
2. From full, assert wr_en for one extra cycle with data 0xDEAD.
   -> write rejected; overflow=1 next cycle and sticky; level=16.
   Then pulse clear_err -> overflow=0.
3. From full, wr_en and rd_en together with data 0xBEEF.
   -> data_out=0x100 one cycle later; level stays 16.
   Drain 16 reads -> 0x101..0x10F then 0xBEEF; empty=1.
4. Empty FIFO, rd_en=1 and wr_en=1 with 0x55 in the same cycle.
   -> read rejected; underflow=1; level=1.
   Next read -> data_out=0x55.
5. FWFT=1, empty. Write 0xA1 then 0xA2.
   -> cycle after the first write: empty=0 and data_out=0xA1 with no rd_en.
   rd_en -> data_out=0xA2 next cycle; second rd_en -> empty=1.
6. With level=5, assert flush together with wr_en.
   -> level=0, empty=1 next cycle; write dropped; no error flags.
   Then drive resetn=0 mid-burst -> all outputs at their reset values asynchronously.
   Wrap check: 40 write/read pairs keep data in order across pointer wrap.
